muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin an operation, sampled only in IDLE.
REQ-006 op  input  1  0 = signed MULT, 1 = signed DIV.
REQ-007 a  input  32  multiplicand or dividend (rs), two's complement.
REQ-008 b  input  32  multiplier or divisor (rt), two's complement.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 hi  output  32  HI register: product[63:32] or remainder.
REQ-012 lo  output  32  LO register: product[31:0] or quotient.
REQ-013 div_zero  output  1  divide-by-zero flag, pulsed with done.

Function
REQ-014 The FSM SHALL have the states IDLE, MULT, DIV, FIX and DONE.
REQ-015 IDLE with start=1 SHALL capture a, b and op at the same edge (edge T) and enter MULT or DIV according to op.
REQ-016 Operand inputs SHALL be ignored after capture.
REQ-017 start SHALL be ignored in every state other than IDLE, with no queuing.
REQ-018 MULT SHALL use radix-2 Booth, one iteration per cycle, for exactly 32 cycles, then enter FIX.
REQ-019 DIV SHALL use restoring division on operand magnitudes, one quotient bit per cycle, for exactly 32 cycles, then enter FIX.
REQ-020 FIX SHALL last 1 cycle: for MULT it passes the 64-bit product through; for DIV it negates the quotient if the operand signs differ and gives the remainder the sign of the dividend.
REQ-021 The DIV result SHALL truncate toward zero.
REQ-022 DONE SHALL last 1 cycle with done=1, and SHALL then return to IDLE.
REQ-023 hi/lo SHALL be written at the edge entering DONE and held until the next completion.
REQ-024 Normal latency: done=1 in cycle T+34; busy=1 in cycles T+1 through T+33, and busy=0 in the DONE cycle.
REQ-025 A new start SHALL be accepted in the cycle after DONE.
REQ-026 0x80000000 / 0xFFFFFFFF SHALL produce lo=0x80000000 and hi=0x00000000, with no flag.
REQ-027 MULT results SHALL be the full 64-bit signed product and SHALL never overflow.
REQ-028 div_zero SHALL be 0 except as defined in Configuration.

Reset
REQ-029 reset=0 SHALL immediately force IDLE with busy=0, done=0, div_zero=0, hi=0 and lo=0, and SHALL clear all iteration registers.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no done pulse; the aborted operation SHALL leave no partial result visible.
REQ-031 After reset is released, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-032 When MULDIV_DIV0_TRAP_EN is defined, DIV with b=0 SHALL go from IDLE directly to DONE.
REQ-033 In that case done=1 and div_zero=1 SHALL occur in cycle T+1, and hi/lo SHALL be left unchanged.
REQ-034 When MULDIV_DIV0_TRAP_EN is undefined, DIV with b=0 SHALL run the normal 34-cycle path and produce hi=a and lo=0xFFFFFFFF regardless of sign, with div_zero tied to 0.

Verification
REQ-035 MULT a=7, b=0xFFFFFFFD -> done at T+34, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-036 MULT a=b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001; busy high exactly 33 cycles.
REQ-037 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 DIV a=5, b=0 -> with the macro: done and div_zero at T+1, hi/lo keep their prior values. Without the macro: done at T+34, hi=5, lo=0xFFFFFFFF, div_zero=0.
REQ-039 Pulse start with changed operands during cycles T+5 and T+34 -> both ignored, and the first result is unaffected.
REQ-040 Assert reset=0 at iteration 10 of a MULT -> busy=0, hi=lo=0, no done; a fresh MULT 3*4 then gives lo=12, hi=0.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: 32-bit signed multiply (radix-2 Booth) / divide (restoring).
// Optional MULDIV_DIV0_TRAP_EN: DIV by zero finishes at once with div_zero.
module muldiv_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  typedef enum logic [2:0] {
    IDLE, MULT, DIV, FIX, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [32:0] acc_q;
  logic [31:0] q_q;
  logic        qm1_q;
  logic [32:0] m_q;
  logic [4:0]  cnt_q;
  logic        div_q;
  logic        neg_q_q;
  logic        neg_r_q;

  logic        trap;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] booth_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] rem_fix;
  logic [31:0] quo_fix;

`ifdef MULDIV_DIV0_TRAP_EN
  logic dz_q;
  assign trap     = op && (b == 32'd0);
  assign div_zero = dz_q;

  // divide-by-zero flag lives exactly for the DONE cycle of a trap
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) dz_q <= 1'b0;
    else        dz_q <= (state_q == IDLE) && start && trap;
  end
`else
  assign trap     = 1'b0;
  assign div_zero = 1'b0;
`endif

  assign mag_a = a[31] ? -a : a;
  assign mag_b = b[31] ? -b : b;
  assign busy  = (state_q == MULT) || (state_q == DIV) ||
                 (state_q == FIX);
  assign done  = (state_q == DONE);

  assign div_shift = {acc_q[31:0], q_q[31]};
  assign div_ge    = (div_shift >= m_q);
  assign rem_fix   = neg_r_q ? -acc_q[31:0] : acc_q[31:0];
  assign quo_fix   = neg_q_q ? -q_q : q_q;

  // Booth recoding of the multiplier LSB pair
  always_comb begin
    booth_sum = acc_q;
    unique case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_q;
      2'b10:   booth_sum = acc_q - m_q;
      default: booth_sum = acc_q;
    endcase
  end

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (trap)    state_d = DONE;
          else if (op) state_d = DIV;
          else         state_d = MULT;
        end
      end
      MULT, DIV: begin
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // iteration datapath and result registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !trap) begin
            acc_q <= '0;
            qm1_q <= 1'b0;
            cnt_q <= '0;
            div_q <= op;
            if (op) begin
              q_q     <= mag_a;
              m_q     <= {1'b0, mag_b};
              neg_q_q <= (a[31] ^ b[31]) && (b != 32'd0);
              neg_r_q <= a[31];
            end else begin
              q_q     <= b;
              m_q     <= {a[31], a};
              neg_q_q <= 1'b0;
              neg_r_q <= 1'b0;
            end
          end
        end
        MULT: begin
          acc_q <= {booth_sum[32], booth_sum[32:1]};
          q_q   <= {booth_sum[0], q_q[31:1]};
          qm1_q <= q_q[0];
          cnt_q <= cnt_q + 5'd1;
        end
        DIV: begin
          acc_q <= div_ge ? (div_shift - m_q) : div_shift;
          q_q   <= {q_q[30:0], div_ge};
          cnt_q <= cnt_q + 5'd1;
        end
        FIX: begin
          if (div_q) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= acc_q[31:0];
            lo <= q_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scoreboard bench for muldiv_ctrl.
// Reference results come from native 64-bit signed arithmetic.
module tb_muldiv_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op    = 1'b0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_hi  = '0;
  logic [31:0] last_lo  = '0;

  muldiv_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  function automatic exp_t model(input logic o,
                                 input logic [31:0] x,
                                 input logic [31:0] y);
    exp_t   e;
    longint sx, sy, p, qt, rm;
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    e.dz  = 1'b0;
    e.lat = 34;
    if (!o) begin
      p    = sx * sy;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (y == 32'd0) begin
`ifdef MULDIV_DIV0_TRAP_EN
      e.hi  = last_hi;
      e.lo  = last_lo;
      e.dz  = 1'b1;
      e.lat = 1;
`else
      e.hi = x;
      e.lo = 32'hFFFFFFFF;
`endif
    end else begin
      qt   = sx / sy;
      rm   = sx % sy;
      e.hi = rm[31:0];
      e.lo = qt[31:0];
    end
    return e;
  endfunction

  // Issues one op at the current negedge, optionally pulses junk
  // starts at cycles pa/pb, drains the scoreboard on done.
  task automatic run(input logic o, input logic [31:0] x,
                     input logic [31:0] y, input int pa, input int pb);
    exp_t e;
    int   n;
    int   bn;
    sb.push_back(model(o, x, y));
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    n     = 0;
    bn    = 0;
    do begin
      @(negedge clock);
      n++;
      if (busy) bn++;
      start = (n == pa) || (n == pb);
      op    = 1'($urandom);
      a     = $urandom;
      b     = $urandom;
    end while (!done && n < 100);
    e = sb.pop_front();
    checks++;
    if (n !== e.lat)
      $display("FAIL latency op=%0b a=%h b=%h got=%0d exp=%0d",
               o, x, y, n, e.lat);
    checks++;
    if (hi !== e.hi)
      $display("FAIL hi op=%0b a=%h b=%h got=%h exp=%h",
               o, x, y, hi, e.hi);
    checks++;
    if (lo !== e.lo)
      $display("FAIL lo op=%0b a=%h b=%h got=%h exp=%h",
               o, x, y, lo, e.lo);
    checks++;
    if (div_zero !== e.dz)
      $display("FAIL div_zero op=%0b a=%h b=%h got=%b exp=%b",
               o, x, y, div_zero, e.dz);
    checks++;
    if (bn !== e.lat - 1)
      $display("FAIL busy_cycles a=%h b=%h got=%0d exp=%0d",
               x, y, bn, e.lat - 1);
    if (n != e.lat) failures++;
    if (hi !== e.hi) failures++;
    if (lo !== e.lo) failures++;
    if (div_zero !== e.dz) failures++;
    if (bn !== e.lat - 1) failures++;
    last_hi = e.hi;
    last_lo = e.lo;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== e.hi || lo !== e.lo) begin
      failures++;
      $display("FAIL after_done busy=%b done=%b hi=%h lo=%h exp 0 0 %h %h",
               busy, done, hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (done !== 1'b0 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags done=%b dz=%b exp=0", done, div_zero);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_hilo hi=%h lo=%h exp=0", hi, lo);
    end
    reset = 1'b1;
  endtask

  task automatic test_mult;
    run(1'b0, 32'd7, 32'hFFFFFFFD, 0, 0);
    run(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0);
    run(1'b0, 32'h80000000, 32'h80000000, 0, 0);
    run(1'b0, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    run(1'b0, 32'h80000000, 32'h7FFFFFFF, 0, 0);
    run(1'b0, 32'd0, 32'h12345678, 0, 0);
    for (int i = 0; i < 4; i++)
      run(1'b0, $urandom, $urandom, 0, 0);
  endtask

  task automatic test_div;
    run(1'b1, 32'hFFFFFFF9, 32'd2, 0, 0);
    run(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    run(1'b1, 32'd7, 32'hFFFFFFFE, 0, 0);
    run(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 0, 0);
    run(1'b1, 32'd0, 32'd5, 0, 0);
    run(1'b1, 32'h80000000, 32'd1, 0, 0);
    run(1'b1, 32'd100, 32'd7, 0, 0);
    run(1'b1, 32'd3, 32'd100, 0, 0);
    for (int i = 0; i < 4; i++)
      run(1'b1, $urandom, $urandom_range(1, 32'h0000FFFF), 0, 0);
  endtask

  task automatic test_div_zero;
    run(1'b0, 32'h00010001, 32'h00030003, 0, 0);
    run(1'b1, 32'd5, 32'd0, 0, 0);
    run(1'b1, 32'hFFFFFFFB, 32'd0, 0, 0);
  endtask

  task automatic test_start_ignored;
    run(1'b0, 32'd1000, 32'hFFFFFF38, 5, 34);
    run(1'b1, 32'h7FFFFFFF, 32'd3, 5, 34);
  endtask

  task automatic test_back_to_back;
    run(1'b1, 32'hFFFF0000, 32'd9, 0, 0);
    run(1'b0, 32'hDEADBEEF, 32'h0BADF00D, 0, 0);
    run(1'b1, 32'd12345, 32'hFFFFFFF0, 0, 0);
  endtask

  task automatic test_reset_abort;
    logic saw_done;
    start = 1'b1;
    op    = 1'b0;
    a     = 32'h00ABCDEF;
    b     = 32'h0FEDCBA9;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL abort_flags busy=%b done=%b dz=%b exp=0",
               busy, done, div_zero);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL abort_hilo hi=%h lo=%h exp=0", hi, lo);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_done got=1 exp=0");
    end
    reset   = 1'b1;
    last_hi = '0;
    last_lo = '0;
    run(1'b0, 32'd3, 32'd4, 0, 0);
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_start_ignored;
    test_back_to_back;
    test_reset_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
